if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
Instruction-fetch front end. It drives the IF/ID pipeline register's inputs (pc_plus_4, if_ins, flush) and honours that register's stall input (BranchBubble). It owns the fetch PC, issues word-address requests to instruction memory over a req/ack handshake, and buffers one response when the pipeline is stalled. It handles branch/jump redirects, including discarding a fetch already in flight.

Parameters:
RESET_PC, 30'h0, word address fetched first after reset
PC_W, 30, word-address width; fixed, matches pc_plus_4

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
stall  in  1  BranchBubble from hazard unit; IF/ID holds, fetch output must hold
redirect  in  1  taken branch/jump this cycle
redirect_target  in  30  new word address
imem_req  out  1  fetch request
imem_addr  out  30  word address of request
imem_ack  in  1  response valid this cycle (same-cycle ack allowed)
imem_rdata  in  32  instruction word, valid with imem_ack
if_ins  out  32  fetched instruction to IF/ID
pc_plus_4  out  30  fetched word address + 1 to IF/ID
if_valid  out  1  if_ins/pc_plus_4 hold a live instruction
if_flush  out  1  equals !if_valid; drives IF/ID flush (bubble insert)

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC; state=RUN; skid empty; if_ins=0; pc_plus_4=0; if_valid=0; if_flush=1; imem_req low while rst high.
- States: RUN (normal fetch), DROP (one request outstanding whose response is to be discarded).
- Memory rule: once imem_req is high, imem_req and imem_addr stay stable until the imem_ack cycle. Memory never acks without req.
- imem_req = (state==DROP) || (state==RUN && !skid_valid). imem_addr = drop_addr in DROP, fetch_pc in RUN.
- Output slot is free this cycle when !if_valid || !stall.
- RUN, ack, no redirect:
  - fetch_pc <= fetch_pc+1 (mod 2^30).
  - If the slot is free: if_ins<=imem_rdata, pc_plus_4<=fetch_pc+1, if_valid<=1.
  - Otherwise the response goes into the skid buffer. The skid is always empty here, because req is low while the skid is full.
- Slot free, no ack, skid valid: skid moves to output; skid emptied.
- Slot free, no ack, skid empty: if_valid<=0 (bubble).
- stall with valid output: output registers hold unchanged.
- redirect (priority over stall and ack):
  - if_valid<=0; skid cleared; fetch_pc<=redirect_target.
  - If imem_req && !imem_ack this cycle: drop_addr<=imem_addr, state<=DROP.
  - If ack in the same cycle: data discarded, state stays RUN.
- DROP: on ack, data discarded, state<=RUN. A further redirect in DROP only updates fetch_pc.
- Latency:
  - Zero-wait memory: one instruction per cycle.
  - Redirect at cycle N (no request in flight): request for the target at N+1; if_valid with the target at edge ending N+1.
- Simultaneous skid drain and response is impossible: req is low while the skid is valid.
- Width: all PC arithmetic is 30-bit and wraps; 3FFFFFFF+1 = 0.

Decomposition:
- Shared pipeline package holds: PC_W=30, INS_W=32, NOP_INS=32'h0, fetch state enum {RUN, DROP}.
- One natural sub-module: if_skid_buf, a one-entry {ins, pc_plus_4} buffer with valid, load, drain and clear.

Test Plan:
- Reset then zero-wait ack every cycle, RESET_PC=0 -> addrs 0,1,2,3 on consecutive cycles; pc_plus_4 1,2,3,4; if_valid high from the second edge; if_flush 0.
- Stall high 3 cycles with ack on the first -> output holds addr-1 instruction; second response sits in skid; req low 2 cycles; after release skid appears first, then req resumes at the next address.
- Redirect to 0x100 while req at 0x05 is unacked, ack 2 cycles later with 0xDEADBEEF -> data discarded, if_valid 0; next req addr 0x100; pc_plus_4 0x101.
- Redirect and ack in the same cycle -> if_valid 0 next edge; next req addr = target.
- fetch_pc 3FFFFFFF, ack -> pc_plus_4 0; next imem_addr 0.
- rst asserted mid-DROP -> req low immediately; after release, first req at RESET_PC; stale ack ignored.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch front end.
//   PC_W     : word-address width (fixed, matches pc_plus_4)
//   INS_W    : instruction word width
//   NOP_INS  : value presented on if_ins when nothing has been fetched yet
//   fetch_state_e : RUN (normal fetch) / DROP (one stale response to discard)
//   pc_inc   : 30-bit wrapping word-address increment
package if_fetch_unit_pkg;

    localparam int PC_W  = 30;
    localparam int INS_W = 32;

    localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } fetch_state_e;

    // Next sequential word address; wraps 3FFFFFFF -> 0.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 30'd1;
    endfunction

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// One-entry {ins, pc_plus_4} holding buffer used while IF/ID is stalled.
//   clk, rst      : clock, asynchronous active-high reset
//   load          : capture load_ins/load_pc, entry becomes valid
//   drain         : entry consumed, becomes empty
//   clear         : discard entry (redirect); highest priority
//   valid, ins, pc_plus_4 : buffered entry
module if_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic             clear,
    input  logic [INS_W-1:0] load_ins,
    input  logic [PC_W-1:0]  load_pc,
    output logic             valid,
    output logic [INS_W-1:0] ins,
    output logic [PC_W-1:0]  pc_plus_4
);

    logic             valid_r;
    logic [INS_W-1:0] ins_r;
    logic [PC_W-1:0]  pc_r;

    // Entry valid flag: clear wins over load, load wins over drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
        end else if (drain) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Entry payload: only written on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_r <= NOP_INS;
            pc_r  <= 30'h0;
        end else if (load && !clear) begin
            ins_r <= load_ins;
            pc_r  <= load_pc;
        end else begin
            ins_r <= ins_r;
            pc_r  <= pc_r;
        end
    end

    assign valid     = valid_r;
    assign ins       = ins_r;
    assign pc_plus_4 = pc_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID pipeline register.
// Owns the fetch PC, issues word-address requests over a req/ack handshake,
// buffers one response while IF/ID is stalled, and handles redirects,
// discarding a request that is still in flight when the redirect arrives.
//   clk, rst                   : clock, asynchronous active-high reset
//   stall                      : IF/ID hold (BranchBubble)
//   redirect, redirect_target  : taken branch/jump and its word address
//   imem_req, imem_addr        : request to instruction memory
//   imem_ack, imem_rdata       : response (may arrive in the request cycle)
//   if_ins, pc_plus_4          : fetched instruction and its address + 1
//   if_valid, if_flush         : live-instruction flag and its inverse
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_target,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [INS_W-1:0] imem_rdata,
    output logic [INS_W-1:0] if_ins,
    output logic [PC_W-1:0]  pc_plus_4,
    output logic             if_valid,
    output logic             if_flush
);

    fetch_state_e     state_r, state_s;
    logic [PC_W-1:0]  fetch_pc_r, fetch_pc_s;
    logic [PC_W-1:0]  drop_addr_r, drop_addr_s;
    logic [INS_W-1:0] ins_r, ins_s;
    logic [PC_W-1:0]  pc4_r, pc4_s;
    logic             valid_r, valid_s;
    logic             flush_r;

    logic             req_s;
    logic             slot_free_s;
    logic             take_s;
    logic [PC_W-1:0]  fetch_pc_inc_s;
    logic             skid_load_s, skid_drain_s, skid_clear_s;
    logic             skid_valid_s;
    logic [INS_W-1:0] skid_ins_s;
    logic [PC_W-1:0]  skid_pc_s;

    if_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load_s),
        .drain     (skid_drain_s),
        .clear     (skid_clear_s),
        .load_ins  (imem_rdata),
        .load_pc   (fetch_pc_inc_s),
        .valid     (skid_valid_s),
        .ins       (skid_ins_s),
        .pc_plus_4 (skid_pc_s)
    );

    // Request is held back while the skid is occupied so a response can
    // never collide with a skid drain; a DROP request must stay up until acked.
    assign req_s          = (state_r == ST_DROP) || !skid_valid_s;
    assign imem_req       = req_s && !rst;
    assign imem_addr      = (state_r == ST_DROP) ? drop_addr_r : fetch_pc_r;
    assign slot_free_s    = !valid_r || !stall;
    assign take_s         = (state_r == ST_RUN) && imem_ack && !redirect;
    assign fetch_pc_inc_s = pc_inc(fetch_pc_r);

    // Next-state, fetch PC and output-slot decisions.
    always_comb begin
        state_s      = state_r;
        fetch_pc_s   = fetch_pc_r;
        drop_addr_s  = drop_addr_r;
        ins_s        = ins_r;
        pc4_s        = pc4_r;
        valid_s      = valid_r;
        skid_load_s  = 1'b0;
        skid_drain_s = 1'b0;
        skid_clear_s = 1'b0;

        if (redirect) begin
            valid_s      = 1'b0;
            skid_clear_s = 1'b1;
            fetch_pc_s   = redirect_target;
            if (state_r == ST_DROP) begin
                // Already discarding: only the response ends the drop.
                if (imem_ack) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_DROP;
                end
            end else if (req_s && !imem_ack) begin
                // Request in flight for the old path: remember it and discard.
                drop_addr_s = fetch_pc_r;
                state_s     = ST_DROP;
            end else begin
                state_s = ST_RUN;
            end
        end else if (take_s) begin
            fetch_pc_s = fetch_pc_inc_s;
            if (slot_free_s) begin
                ins_s   = imem_rdata;
                pc4_s   = fetch_pc_inc_s;
                valid_s = 1'b1;
            end else begin
                skid_load_s = 1'b1;
            end
        end else begin
            if ((state_r == ST_DROP) && imem_ack) begin
                state_s = ST_RUN;
            end else begin
                state_s = state_r;
            end
            if (slot_free_s) begin
                if (skid_valid_s) begin
                    ins_s        = skid_ins_s;
                    pc4_s        = skid_pc_s;
                    valid_s      = 1'b1;
                    skid_drain_s = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end else begin
                valid_s = valid_r;
            end
        end
    end

    // Fetch control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            fetch_pc_r  <= RESET_PC;
            drop_addr_r <= 30'h0;
        end else begin
            state_r     <= state_s;
            fetch_pc_r  <= fetch_pc_s;
            drop_addr_r <= drop_addr_s;
        end
    end

    // IF/ID-facing output registers; flush is registered alongside valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_r   <= NOP_INS;
            pc4_r   <= 30'h0;
            valid_r <= 1'b0;
            flush_r <= 1'b1;
        end else begin
            ins_r   <= ins_s;
            pc4_r   <= pc4_s;
            valid_r <= valid_s;
            flush_r <= !valid_s;
        end
    end

    assign if_ins    = ins_r;
    assign pc_plus_4 = pc4_r;
    assign if_valid  = valid_r;
    assign if_flush  = flush_r;

endmodule
